// File: rtl/gpio_int_pkg.sv
// Shared types and widths for the interrupt-acknowledge block and its vector FIFO.
package gpio_int_pkg;

  localparam int CODE_W = 7;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLY  = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_int_vfifo.sv
// Show-ahead vector FIFO. The head reads as zero while the FIFO is empty.
module gpio_int_vfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits, so the increment wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gpio_int_ack.sv
// Interrupt acknowledge sequencer: answers INTR with a one-cycle INTA_N pulse
// after a programmable delay and queues the returned vector codes.
module gpio_int_ack
  import gpio_int_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_DLY    = 1
) (
  input  logic                          clk_cpu,
  input  logic                          rstn_cpu,
  input  logic                          INTR,
  input  logic [CODE_W-1:0]             INT_CODE,
  output logic                          INTA_N,
  input  logic                          ack_en,
  output logic                          vec_valid,
  output logic [CODE_W-1:0]             vec_code,
  input  logic                          vec_ready,
  output logic [$clog2(FIFO_DEPTH):0]   pend_cnt,
  output logic                          spur_flag,
  input  logic                          spur_clr,
  output logic                          busy
);

  // Consumer handshake: an entry is popped on every clk_cpu edge where
  // vec_valid and vec_ready are both high; vec_code holds while vec_ready is low.

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic             inta_n_q, inta_n_d;
  logic             spur_q, spur_d;
  logic             push, spur_set;
  logic             fifo_full, fifo_empty;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    push     = 1'b0;
    spur_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A full FIFO blocks new acknowledges, so a push can never overflow.
        if (INTR && ack_en && !fifo_full) begin
          if (ACK_DLY == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_DLY;
            dly_d   = CNT_W'(ACK_DLY - 1);
          end
        end
      end
      ST_DLY: begin
        if (!INTR) begin
          state_d  = ST_IDLE;
          spur_set = 1'b1;
        end else if (!ack_en) begin
          state_d = ST_IDLE;
        end else if (dly_q == '0) begin
          state_d = ST_ACK;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_GAP;
        if (INTR) push = 1'b1;
        else      spur_set = 1'b1;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    inta_n_d = (state_d != ST_ACK);
    spur_d   = spur_set ? 1'b1 : (spur_clr ? 1'b0 : spur_q);
  end

  always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
    if (!rstn_cpu) begin
      state_q  <= ST_IDLE;
      dly_q    <= '0;
      inta_n_q <= 1'b1;
      spur_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      inta_n_q <= inta_n_d;
      spur_q   <= spur_d;
    end
  end

  gpio_int_vfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_vfifo (
    .clk_i   (clk_cpu),
    .rst_ni  (rstn_cpu),
    .push_i  (push),
    .data_i  (INT_CODE),
    .pop_i   (vec_ready),
    .head_o  (vec_code),
    .count_o (pend_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign INTA_N    = inta_n_q;
  assign vec_valid = ~fifo_empty;
  assign spur_flag = spur_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_int_ack.sv
// Bench for gpio_int_ack: directed scenarios plus a randomized run against a
// timeline-and-queue reference model.
module tb_gpio_int_ack;

  localparam int DEPTH = 4;
  localparam int DLY   = 1;
  localparam int DLY3  = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          intr, ack_en, vec_ready, spur_clr;
  logic [6:0]    code;
  logic          inta_n, vec_valid, spur_flag, busy;
  logic [6:0]    vec_code;
  logic [CW-1:0] pend_cnt;

  logic          intr3, ack_en3, vec_ready3, spur_clr3;
  logic [6:0]    code3;
  logic          inta_n3, vec_valid3, spur_flag3, busy3;
  logic [6:0]    vec_code3;
  logic [CW-1:0] pend_cnt3;

  int total = 0;
  int bad   = 0;

  // Reference model: m_age counts edges since the request was accepted
  // (-1 = idle); the acknowledge pulse is visible while m_age == DLY.
  int         m_age;
  logic [6:0] m_q[$];
  logic       m_spur;
  int         m_push_cnt;

  gpio_int_ack #(.FIFO_DEPTH(DEPTH), .ACK_DLY(DLY)) u_dut (
    .clk_cpu(clk), .rstn_cpu(rstn), .INTR(intr), .INT_CODE(code),
    .INTA_N(inta_n), .ack_en(ack_en), .vec_valid(vec_valid),
    .vec_code(vec_code), .vec_ready(vec_ready), .pend_cnt(pend_cnt),
    .spur_flag(spur_flag), .spur_clr(spur_clr), .busy(busy)
  );

  gpio_int_ack #(.FIFO_DEPTH(DEPTH), .ACK_DLY(DLY3)) u_dut3 (
    .clk_cpu(clk), .rstn_cpu(rstn), .INTR(intr3), .INT_CODE(code3),
    .INTA_N(inta_n3), .ack_en(ack_en3), .vec_valid(vec_valid3),
    .vec_code(vec_code3), .vec_ready(vec_ready3), .pend_cnt(pend_cnt3),
    .spur_flag(spur_flag3), .spur_clr(spur_clr3), .busy(busy3)
  );

  task automatic model_reset();
    m_age  = -1;
    m_q.delete();
    m_spur = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then move 1 time unit past the edge for sampling.
  task automatic step();
    bit         sp_set;
    bit         do_push;
    logic [6:0] pcode;
    @(posedge clk);
    sp_set  = 1'b0;
    do_push = 1'b0;
    pcode   = code;
    if (m_age < 0) begin
      if (intr && ack_en && m_q.size() < DEPTH) m_age = 0;
    end else if (m_age < DLY) begin
      if (!intr) begin
        m_age  = -1;
        sp_set = 1'b1;
      end else if (!ack_en) begin
        m_age = -1;
      end else begin
        m_age++;
      end
    end else if (m_age == DLY) begin
      if (intr) do_push = 1'b1;
      else      sp_set  = 1'b1;
      m_age++;
    end else begin
      m_age = -1;
    end
    if (vec_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(pcode);
      m_push_cnt++;
    end
    if (sp_set)        m_spur = 1'b1;
    else if (spur_clr) m_spur = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    intr = 0; ack_en = 0; vec_ready = 0; spur_clr = 0; code = '0;
    intr3 = 0; ack_en3 = 0; vec_ready3 = 0; spur_clr3 = 0; code3 = '0;
    model_reset();
    m_push_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (inta_n !== 1'b1)   begin bad++; $display("FAIL reset_inta: got %b want 1", inta_n); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", vec_valid); end
    total++; if (vec_code !== 7'h00) begin bad++; $display("FAIL reset_code: got %h want 00", vec_code); end
    total++; if (pend_cnt !== '0)    begin bad++; $display("FAIL reset_pend: got %0d want 0", pend_cnt); end
    total++; if (spur_flag !== 1'b0) begin bad++; $display("FAIL reset_spur: got %b want 0", spur_flag); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (inta_n3 !== 1'b1)   begin bad++; $display("FAIL reset_inta3: got %b want 1", inta_n3); end
    @(negedge clk);
    rstn = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic exp_inta;
    code = 7'h05; intr = 1'b1; ack_en = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      if (cyc == 3) intr = 1'b0;
      exp_inta = (cyc == 2) ? 1'b0 : 1'b1;
      total++; if (inta_n !== exp_inta) begin bad++; $display("FAIL basic_inta cyc %0d: got %b want %b", cyc, inta_n, exp_inta); end
    end
    total++; if (vec_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", vec_valid); end
    total++; if (vec_code !== 7'h05) begin bad++; $display("FAIL basic_code: got %h want 05", vec_code); end
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    total++; if (pend_cnt !== '0) begin bad++; $display("FAIL basic_pop: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_backpressure();
    logic [6:0] codes [5];
    int base, acks, idx;
    for (int i = 0; i < 5; i++) codes[i] = 7'(i * 23 + $urandom_range(0, 15));
    base = m_push_cnt; acks = 0;
    vec_ready = 1'b0; ack_en = 1'b1; intr = 1'b1; code = codes[0];
    for (int cyc = 0; cyc < 4 * (DLY + 3) + 8; cyc++) begin
      step();
      if (!inta_n) acks++;
      idx = m_push_cnt - base;
      code = codes[(idx < 5) ? idx : 4];
    end
    total++; if (acks != 4)            begin bad++; $display("FAIL bp_acks: got %0d want 4", acks); end
    total++; if (pend_cnt !== CW'(4))  begin bad++; $display("FAIL bp_pend: got %0d want 4", pend_cnt); end
    total++; if (inta_n !== 1'b1)      begin bad++; $display("FAIL bp_hold: got %b want 1", inta_n); end
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    for (int k = 0; k < 20 && (m_push_cnt - base) < 5; k++) begin
      step();
      if (!inta_n) acks++;
      idx = m_push_cnt - base;
      code = codes[(idx < 5) ? idx : 4];
    end
    intr = 1'b0;
    total++; if (acks != 5) begin bad++; $display("FAIL bp_fifth_ack: got %0d want 5", acks); end
    repeat (3) step();
    for (int i = 1; i < 5; i++) begin
      total++; if (vec_code !== codes[i]) begin bad++; $display("FAIL bp_order %0d: got %h want %h", i, vec_code, codes[i]); end
      vec_ready = 1'b1;
      step();
    end
    vec_ready = 1'b0;
    total++; if (pend_cnt !== '0) begin bad++; $display("FAIL bp_drain: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_spurious();
    logic low_seen;
    intr3 = 1'b1; ack_en3 = 1'b1; code3 = 7'h11;
    step();
    intr3 = 1'b0;
    total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL spur3_dly: got busy %b want 1", busy3); end
    low_seen = 1'b0;
    repeat (6) begin
      step();
      if (!inta_n3) low_seen = 1'b1;
    end
    total++; if (low_seen !== 1'b0) begin bad++; $display("FAIL spur3_noack: got low_seen %b want 0", low_seen); end
    total++; if (busy3 !== 1'b0)    begin bad++; $display("FAIL spur3_idle: got busy %b want 0", busy3); end
    total++; if (spur_flag3 !== 1'b1) begin bad++; $display("FAIL spur3_flag: got %b want 1", spur_flag3); end
    total++; if (pend_cnt3 !== '0)  begin bad++; $display("FAIL spur3_pend: got %0d want 0", pend_cnt3); end
    spur_clr3 = 1'b1;
    step();
    spur_clr3 = 1'b0;
    total++; if (spur_flag3 !== 1'b0) begin bad++; $display("FAIL spur3_clr: got %b want 0", spur_flag3); end
    // Set and clear on the same edge: set must win.
    intr = 1'b1; ack_en = 1'b1;
    step();
    intr = 1'b0; spur_clr = 1'b1;
    step();
    spur_clr = 1'b0;
    total++; if (spur_flag !== m_spur) begin bad++; $display("FAIL spur_set_wins: got %b want %b", spur_flag, m_spur); end
    spur_clr = 1'b1; step(); spur_clr = 1'b0;
    // INTR withdrawn during the acknowledge pulse itself.
    intr = 1'b1; code = 7'h33;
    step(); step();
    intr = 1'b0;
    step();
    total++; if (spur_flag !== 1'b1) begin bad++; $display("FAIL spur_in_ack: got %b want 1", spur_flag); end
    total++; if (pend_cnt !== '0)    begin bad++; $display("FAIL spur_in_ack_pend: got %0d want 0", pend_cnt); end
    spur_clr = 1'b1; step(); spur_clr = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int pairs;
    logic [6:0] e_code;
    vec_ready = 1'b0; intr = 1'b1; ack_en = 1'b1;
    for (int k = 0; k < 40 && m_q.size() < 2; k++) begin
      code = 7'($urandom_range(0, 127));
      step();
    end
    total++; if (pend_cnt !== CW'(2)) begin bad++; $display("FAIL b2b_fill: got %0d want 2", pend_cnt); end
    pairs = 0;
    for (int k = 0; k < 200 && pairs < 10; k++) begin
      vec_ready = (m_age == DLY);
      code = 7'($urandom_range(0, 127));
      step();
      if (vec_ready) begin
        pairs++;
        e_code = m_q[0];
        total++; if (pend_cnt !== CW'(2)) begin bad++; $display("FAIL b2b_pend pair %0d: got %0d want 2", pairs, pend_cnt); end
        total++; if (vec_code !== e_code) begin bad++; $display("FAIL b2b_head pair %0d: got %h want %h", pairs, vec_code, e_code); end
      end
      vec_ready = 1'b0;
    end
    total++; if (pairs != 10) begin bad++; $display("FAIL b2b_pairs: got %0d want 10", pairs); end
    intr = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 6; k++) begin
      e_code = (m_q.size() > 0) ? m_q[0] : 7'h00;
      total++; if (vec_code !== e_code) begin bad++; $display("FAIL b2b_drain %0d: got %h want %h", k, vec_code, e_code); end
      vec_ready = 1'b1;
      step();
    end
    vec_ready = 1'b0;
    spur_clr = 1'b1; step(); spur_clr = 1'b0;
  endtask

  task automatic test_reset_mid_ack();
    intr = 1'b1; ack_en = 1'b1; vec_ready = 1'b0; code = 7'h4C;
    for (int k = 0; k < 30 && !(m_age == DLY && m_q.size() > 0); k++) step();
    total++; if (inta_n !== 1'b0) begin bad++; $display("FAIL rst_ack_low: got %b want 0", inta_n); end
    #1 rstn = 1'b0;
    #1;
    model_reset();
    total++; if (inta_n !== 1'b1)    begin bad++; $display("FAIL rst_ack_inta: got %b want 1", inta_n); end
    total++; if (pend_cnt !== '0)    begin bad++; $display("FAIL rst_ack_pend: got %0d want 0", pend_cnt); end
    total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL rst_ack_valid: got %b want 0", vec_valid); end
    @(negedge clk);
    rstn = 1'b1;
    code = 7'h61;
    step();
    total++; if (inta_n !== 1'b1) begin bad++; $display("FAIL rst_re_c1: got %b want 1", inta_n); end
    step();
    total++; if (inta_n !== 1'b0) begin bad++; $display("FAIL rst_re_c2: got %b want 0", inta_n); end
    step();
    intr = 1'b0;
    total++; if (pend_cnt !== CW'(1) || vec_code !== 7'h61) begin bad++; $display("FAIL rst_re_push: got %0d/%h want 1/61", pend_cnt, vec_code); end
    vec_ready = 1'b1; step(); vec_ready = 1'b0;
    step();
  endtask

  task automatic test_ack_en();
    logic low_seen;
    int n;
    ack_en = 1'b0; intr = 1'b1; code = 7'h2A;
    low_seen = 1'b0;
    repeat (6) begin
      step();
      if (!inta_n) low_seen = 1'b1;
    end
    total++; if (low_seen !== 1'b0) begin bad++; $display("FAIL acken_block: got low_seen %b want 0", low_seen); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL acken_busy: got %b want 0", busy); end
    ack_en = 1'b1;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (!inta_n) begin n = k; break; end
    end
    total++; if (n != DLY + 1) begin bad++; $display("FAIL acken_latency: got %0d want %0d", n, DLY + 1); end
    // Dropping ack_en during the pulse must not abort it.
    ack_en = 1'b0;
    step();
    total++; if (pend_cnt !== CW'(1)) begin bad++; $display("FAIL acken_drop_push: got %0d want 1", pend_cnt); end
    total++; if (busy !== 1'b1)       begin bad++; $display("FAIL acken_gap_busy: got %b want 1", busy); end
    intr = 1'b0; vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic          e_inta, e_busy, e_valid;
    logic [6:0]    e_code;
    logic [CW-1:0] e_cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      intr      = ($urandom_range(0, 3) != 0);
      ack_en    = ($urandom_range(0, 4) != 0);
      vec_ready = ($urandom_range(0, 2) == 0);
      spur_clr  = ($urandom_range(0, 7) == 0);
      code      = 7'($urandom_range(0, 127));
      step();
      e_inta  = (m_age == DLY) ? 1'b0 : 1'b1;
      e_busy  = (m_age >= 0);
      e_cnt   = CW'(m_q.size());
      e_valid = (m_q.size() != 0);
      e_code  = (m_q.size() != 0) ? m_q[0] : 7'h00;
      total++; if (inta_n !== e_inta)    begin bad++; $display("FAIL rand_inta cyc %0d: got %b want %b", cyc, inta_n, e_inta); end
      total++; if (busy !== e_busy)      begin bad++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, busy, e_busy); end
      total++; if (pend_cnt !== e_cnt)   begin bad++; $display("FAIL rand_pend cyc %0d: got %0d want %0d", cyc, pend_cnt, e_cnt); end
      total++; if (vec_valid !== e_valid) begin bad++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, vec_valid, e_valid); end
      total++; if (vec_code !== e_code)  begin bad++; $display("FAIL rand_code cyc %0d: got %h want %h", cyc, vec_code, e_code); end
      total++; if (spur_flag !== m_spur) begin bad++; $display("FAIL rand_spur cyc %0d: got %b want %b", cyc, spur_flag, m_spur); end
    end
    intr = 1'b0; vec_ready = 1'b0; spur_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_spurious();
    test_back_to_back();
    test_reset_mid_ack();
    test_ack_en();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
